// File: rtl/aer_pkg.sv
// Shared constants and receiver FSM state encoding for the AER receive path.
package aer_pkg;
  localparam int N_CH   = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } rx_state_t;
endpackage

// File: rtl/aer_addr_fifo.sv
// First-word-fall-through address buffer; head entry is visible while not empty.
module aer_addr_fifo #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH),
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_data,
  input  logic              i_pop,
  output logic [ADDR_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);
  logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Both qualifiers use the registered flags, so a pop never opens a slot for a same-edge push.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/aer_receiver.sv
// AER link receiver: 4-phase-style req/ack handling with a 3-cycle accept loop,
// address buffering, and one-hot replay to the next layer over valid/ready.
module aer_receiver #(
  parameter int N_CH       = aer_pkg::N_CH,
  parameter int ADDR_W     = aer_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_in,
  input  logic [ADDR_W-1:0]             addr_in,
  output logic                          ack_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [N_CH-1:0]               spikes_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              event_count,
  output logic [1:0]                    o_state
);
  import aer_pkg::*;

  // Handshake: a downstream transfer happens on any edge where out_valid && out_ready;
  // out_valid never drops without a transfer, and out_addr/spikes_out are stable while it is high.

  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [CNT_W-1:0]    r_event_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_head;

  assign w_push = (r_state == IDLE) && req_in && !w_full;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nxt = ACK;
      ACK:     w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_event_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push && (r_event_count != '1)) begin
        r_event_count <= r_event_count + CNT_W'(1);
      end
    end
  end

  aer_addr_fifo #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (addr_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // ack_out decodes the registered state only, so it is glitch-free and exactly one cycle wide.
  assign ack_out     = (r_state == ACK);
  assign out_valid   = !w_empty;
  assign out_addr    = out_valid ? w_head : '0;
  assign spikes_out  = out_valid ? ({{(N_CH-1){1'b0}}, 1'b1} << out_addr) : '0;
  assign event_count = r_event_count;
  assign o_state     = r_state;
endmodule

// File: tb/tb_aer_receiver.sv
// Directed scenarios for the AER receiver: single event, held request, full backpressure,
// simultaneous push/pop, reset in flight and counter saturation.
module tb_aer_receiver;
  logic        clk;
  logic        rst;
  logic        req_in;
  logic [3:0]  addr_in;
  logic        out_ready;
  logic        ack_out;
  logic        out_valid;
  logic [3:0]  out_addr;
  logic [15:0] spikes_out;
  logic [3:0]  fifo_count;
  logic [15:0] event_count;
  logic [1:0]  o_state;

  logic        s_ack_out;
  logic        s_out_valid;
  logic [3:0]  s_out_addr;
  logic [15:0] s_spikes_out;
  logic [3:0]  s_fifo_count;
  logic [3:0]  s_event_count;
  logic [1:0]  s_state;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  aer_receiver dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .spikes_out(spikes_out), .fifo_count(fifo_count), .event_count(event_count),
    .o_state(o_state)
  );

  aer_receiver #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .ack_out(s_ack_out),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr),
    .spikes_out(s_spikes_out), .fifo_count(s_fifo_count), .event_count(s_event_count),
    .o_state(s_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_in = 1'b0; addr_in = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_event(input logic [3:0] a, output bit acked);
    acked = 1'b0;
    req_in = 1'b1;
    addr_in = a;
    for (int c = 0; c < 6 && !acked; c++) begin
      tick();
      if (ack_out) acked = 1'b1;
    end
    req_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b0 || out_addr !== 4'd0 || spikes_out !== 16'h0 ||
        fifo_count !== 4'd0 || event_count !== 16'd0 || o_state !== 2'd0) begin
      n_errors++;
      $display("FAIL reset: ack=%b valid=%b addr=%0d spikes=%h cnt=%0d ev=%0d st=%0d expected all zero",
               ack_out, out_valid, out_addr, spikes_out, fifo_count, event_count, o_state);
    end
  endtask

  task automatic test_single_event();
    do_reset();
    req_in = 1'b1; addr_in = 4'd5;
    tick();
    req_in = 1'b0;
    n_checks++;
    if (ack_out !== 1'b1 || out_valid !== 1'b1 || spikes_out !== 16'h0020 ||
        out_addr !== 4'd5 || fifo_count !== 4'd1 || event_count !== 16'd1) begin
      n_errors++;
      $display("FAIL single_accept: ack=%b valid=%b spikes=%h addr=%0d cnt=%0d ev=%0d expected 1 1 0020 5 1 1",
               ack_out, out_valid, spikes_out, out_addr, fifo_count, event_count);
    end
    tick();
    n_checks++;
    if (ack_out !== 1'b0) begin
      n_errors++;
      $display("FAIL single_ack_width: ack=%b expected 0", ack_out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 4'd0 || spikes_out !== 16'h0 || event_count !== 16'd1) begin
      n_errors++;
      $display("FAIL single_drain: valid=%b cnt=%0d spikes=%h ev=%0d expected 0 0 0000 1",
               out_valid, fifo_count, spikes_out, event_count);
    end
  endtask

  task automatic test_held_request();
    logic [15:0] pending;
    int acks, last_ack, min_gap;
    do_reset();
    pending = 16'h8001;
    exp_q = {4'd0, 4'd15};
    acks = 0; last_ack = -1; min_gap = 99;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      req_in = |pending;
      addr_in = 4'd0;
      for (int b = 15; b >= 0; b--) if (pending[b]) addr_in = 4'(b);
      tick();
      if (ack_out) begin
        if (last_ack >= 0 && (cyc - last_ack - 1) < min_gap) min_gap = cyc - last_ack - 1;
        last_ack = cyc;
        acks++;
        pending[addr_in] = 1'b0;
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL held_order: unexpected addr=%0d with nothing expected", out_addr);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (out_addr !== e) begin
            n_errors++;
            $display("FAIL held_order: addr=%0d expected %0d", out_addr, e);
          end
        end
      end
    end
    req_in = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (acks != 2 || min_gap < 2 || exp_q.size() != 0 || pending !== 16'h0) begin
      n_errors++;
      $display("FAIL held_summary: acks=%0d min_gap=%0d left=%0d pending=%h expected 2 >=2 0 0000",
               acks, min_gap, exp_q.size(), pending);
    end
  endtask

  task automatic test_full();
    bit ok;
    int nack;
    do_reset();
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      send_event(4'(i), ok);
      if (ok) nack++;
    end
    req_in = 1'b1; addr_in = 4'd8;
    ok = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack_out) ok = 1'b1;
    end
    n_checks++;
    if (nack != 8 || ok || fifo_count !== 4'd8 || out_addr !== 4'd0) begin
      n_errors++;
      $display("FAIL full_backpressure: acks=%0d ninth_ack=%b cnt=%0d head=%0d expected 8 0 8 0",
               nack, ok, fifo_count, out_addr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd7 || ack_out !== 1'b0) begin
      n_errors++;
      $display("FAIL full_pop: cnt=%0d ack=%b expected 7 0", fifo_count, ack_out);
    end
    ok = 1'b0;
    for (int c = 0; c < 3 && !ok; c++) begin
      tick();
      if (ack_out) ok = 1'b1;
    end
    req_in = 1'b0;
    n_checks++;
    if (!ok || fifo_count !== 4'd8 || event_count !== 16'd9) begin
      n_errors++;
      $display("FAIL full_ninth_accept: acked=%b cnt=%0d ev=%0d expected 1 8 9", ok, fifo_count, event_count);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_addr !== 4'(i) || spikes_out !== (16'h1 << i)) begin
        n_errors++;
        $display("FAIL full_wrap_order: valid=%b addr=%0d spikes=%h expected 1 %0d %h",
                 out_valid, out_addr, spikes_out, i, 16'h1 << i);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL full_drained: cnt=%0d valid=%b expected 0 0", fifo_count, out_valid);
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    do_reset();
    send_event(4'd3, ok);
    send_event(4'd7, ok);
    send_event(4'd9, ok);
    tick();
    tick();
    n_checks++;
    if (fifo_count !== 4'd3 || out_addr !== 4'd3 || o_state !== 2'd0) begin
      n_errors++;
      $display("FAIL pushpop_setup: cnt=%0d head=%0d st=%0d expected 3 3 0", fifo_count, out_addr, o_state);
    end
    req_in = 1'b1; addr_in = 4'd11; out_ready = 1'b1;
    tick();
    req_in = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (ack_out !== 1'b1 || fifo_count !== 4'd3 || out_addr !== 4'd7 || spikes_out !== 16'h0080) begin
      n_errors++;
      $display("FAIL pushpop_same_edge: ack=%b cnt=%0d head=%0d spikes=%h expected 1 3 7 0080",
               ack_out, fifo_count, out_addr, spikes_out);
    end
  endtask

  task automatic test_reset_mid_ack();
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) send_event(4'(i + 2), ok);
    n_checks++;
    if (ack_out !== 1'b1 || fifo_count !== 4'd4) begin
      n_errors++;
      $display("FAIL midack_setup: ack=%b cnt=%0d expected 1 4", ack_out, fifo_count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b0 || spikes_out !== 16'h0 ||
        event_count !== 16'd0 || fifo_count !== 4'd0) begin
      n_errors++;
      $display("FAIL midack_reset: ack=%b valid=%b spikes=%h ev=%0d cnt=%0d expected 0 0 0000 0 0",
               ack_out, out_valid, spikes_out, event_count, fifo_count);
    end
    send_event(4'd6, ok);
    n_checks++;
    if (!ok || out_addr !== 4'd6 || event_count !== 16'd1 || fifo_count !== 4'd1) begin
      n_errors++;
      $display("FAIL midack_after: acked=%b addr=%0d ev=%0d cnt=%0d expected 1 6 1 1",
               ok, out_addr, event_count, fifo_count);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    int nack;
    do_reset();
    out_ready = 1'b1;
    nack = 0;
    for (int i = 0; i < 20; i++) begin
      send_event(4'(i % 16), ok);
      if (ok) nack++;
    end
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (nack != 20 || event_count !== 16'd20 || s_event_count !== 4'd15) begin
      n_errors++;
      $display("FAIL saturation: acks=%0d ev=%0d sat_ev=%0d expected 20 20 15", nack, event_count, s_event_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; req_in = 1'b0; addr_in = '0; out_ready = 1'b0;
    test_reset();
    test_single_event();
    test_held_request();
    test_full();
    test_push_pop();
    test_reset_mid_ack();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
